// File: rtl/acc_job_ctrl_regs.sv
// Accelerator job control register block: assembles the input vector from host words,
// sequences start/stop with an optional RUN timeout, and buffers results in a show-ahead FIFO.
module acc_job_ctrl_regs #(
  parameter int unsigned IN_WIDTH   = 1024,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned OUT_WIDTH  = 32,
  parameter int unsigned OUT_DEPTH  = 4,
  parameter int unsigned TMO_WIDTH  = 16,
  localparam int unsigned NWORDS    = IN_WIDTH / WORD_WIDTH,
  localparam int unsigned IDX_W     = (NWORDS > 1) ? $clog2(NWORDS) : 1,
  localparam int unsigned CNT_W     = $clog2(OUT_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ctrl_wr_en,
  input  logic                 ctrl_start_wr,
  input  logic                 ctrl_stop_wr,
  input  logic                 in_wr_en,
  input  logic [IDX_W-1:0]     in_wr_idx,
  input  logic [WORD_WIDTH-1:0] in_wr_data,
  input  logic [TMO_WIDTH-1:0] tmo_limit,
  input  logic                 acc_out_valid,
  input  logic                 acc_out_last,
  input  logic [OUT_WIDTH-1:0] acc_out_data,
  input  logic                 out_rd_en,
  output logic                 acc_start,
  output logic [IN_WIDTH-1:0]  in_data_reg,
  output logic                 in_loaded,
  output logic [OUT_WIDTH-1:0] out_rd_data,
  output logic [CNT_W-1:0]     out_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err_timeout,
  output logic                 err_overflow
);

  localparam int unsigned PTR_W = $clog2(OUT_DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [IN_WIDTH-1:0]    in_data_q, in_data_d;
  logic [NWORDS-1:0]      mask_q, mask_d;
  logic                   acc_start_q, acc_start_d;
  logic                   done_q, done_d;
  logic                   err_tmo_q, err_tmo_d;
  logic                   err_ovf_q, err_ovf_d;
  logic [TMO_WIDTH-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [OUT_WIDTH-1:0]   mem_q [OUT_DEPTH];
  logic [OUT_WIDTH-1:0]   mem_d [OUT_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   stop_req;
  logic                   start_req;
  logic                   start_ok;
  logic                   in_wr_ok;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop_ok;
  logic                   push_req;
  logic                   push_ok;
  logic                   last_beat;
  logic                   tmo_hit;
  logic [TMO_WIDTH-1:0]   tmo_cnt_inc;

  // Stop always wins over a start carried in the same control write.
  assign stop_req   = ctrl_wr_en & ctrl_stop_wr;
  assign start_req  = ctrl_wr_en & ctrl_start_wr & ~ctrl_stop_wr;
  assign start_ok   = start_req & in_loaded & (state_q != StRun);
  assign in_wr_ok   = in_wr_en & (state_q != StRun);

  assign fifo_full  = (count_q == CNT_W'(OUT_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign pop_ok     = out_rd_en & ~fifo_empty;
  assign push_req   = (state_q == StRun) & acc_out_valid;
  // A full FIFO can still take a beat when the head leaves in the same cycle.
  assign push_ok    = push_req & (~fifo_full | pop_ok);
  assign last_beat  = push_req & acc_out_last;

  assign tmo_cnt_inc = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + TMO_WIDTH'(1);
  // A last beat arriving on the limit cycle counts as completion, not timeout.
  assign tmo_hit     = (state_q == StRun) & (tmo_limit != '0) &
                       (tmo_cnt_inc >= tmo_limit) & ~last_beat;

  // Job FSM and status flags.
  always_comb begin
    state_d     = state_q;
    acc_start_d = 1'b0;
    done_d      = done_q;
    err_tmo_d   = err_tmo_q;
    err_ovf_d   = err_ovf_q;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          state_d     = StRun;
          acc_start_d = 1'b1;
          done_d      = 1'b0;
          err_tmo_d   = 1'b0;
          err_ovf_d   = 1'b0;
          tmo_cnt_d   = '0;
        end
      end
      StRun: begin
        tmo_cnt_d = tmo_cnt_inc;
        if (last_beat) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (tmo_hit) begin
          state_d   = StIdle;
          err_tmo_d = 1'b1;
        end
        if (push_req && !push_ok) begin
          err_ovf_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (stop_req) begin
      state_d     = StIdle;
      acc_start_d = 1'b0;
      done_d      = 1'b0;
      err_tmo_d   = 1'b0;
      err_ovf_d   = 1'b0;
      tmo_cnt_d   = '0;
    end
  end

  // Input vector assembly; out-of-range indices match no word and are dropped.
  always_comb begin
    in_data_d = in_data_q;
    mask_d    = mask_q;
    for (int k = 0; k < NWORDS; k++) begin
      if (in_wr_ok && (in_wr_idx == IDX_W'(k))) begin
        in_data_d[k*WORD_WIDTH +: WORD_WIDTH] = in_wr_data;
        mask_d[k]                             = 1'b1;
      end
    end
    if (start_ok || stop_req) begin
      mask_d = '0;
    end
  end

  // Result FIFO; pointers wrap naturally since OUT_DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = acc_out_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (stop_req) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      in_data_q   <= '0;
      mask_q      <= '0;
      acc_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_tmo_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_data_q   <= in_data_d;
      mask_q      <= mask_d;
      acc_start_q <= acc_start_d;
      done_q      <= done_d;
      err_tmo_q   <= err_tmo_d;
      err_ovf_q   <= err_ovf_d;
      tmo_cnt_q   <= tmo_cnt_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign acc_start    = acc_start_q;
  assign in_data_reg  = in_data_q;
  assign in_loaded    = &mask_q;
  assign out_rd_data  = mem_q[rd_ptr_q];
  assign out_count    = count_q;
  assign busy         = (state_q == StRun);
  assign done         = done_q;
  assign err_timeout  = err_tmo_q;
  assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_acc_job_ctrl_regs.sv
// Scoreboard bench for acc_job_ctrl_regs: directed jobs with hand-computed expectations;
// a negedge monitor checks acc_start pulses and popped FIFO data against queued values.
module tb_acc_job_ctrl_regs;

  localparam int unsigned IN_WIDTH   = 1024;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned OUT_WIDTH  = 32;
  localparam int unsigned OUT_DEPTH  = 4;
  localparam int unsigned TMO_WIDTH  = 16;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned CNT_W      = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  ctrl_wr_en, ctrl_start_wr, ctrl_stop_wr;
  logic                  in_wr_en;
  logic [IDX_W-1:0]      in_wr_idx;
  logic [WORD_WIDTH-1:0] in_wr_data;
  logic [TMO_WIDTH-1:0]  tmo_limit;
  logic                  acc_out_valid, acc_out_last;
  logic [OUT_WIDTH-1:0]  acc_out_data;
  logic                  out_rd_en;
  logic                  acc_start;
  logic [IN_WIDTH-1:0]   in_data_reg;
  logic                  in_loaded;
  logic [OUT_WIDTH-1:0]  out_rd_data;
  logic [CNT_W-1:0]      out_count;
  logic                  busy, done, err_timeout, err_overflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_start_q[$];
  logic [OUT_WIDTH-1:0] exp_pop_q[$];

  acc_job_ctrl_regs #(
    .IN_WIDTH  (IN_WIDTH),
    .WORD_WIDTH(WORD_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .OUT_DEPTH (OUT_DEPTH),
    .TMO_WIDTH (TMO_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_wr_en   (ctrl_wr_en),
    .ctrl_start_wr(ctrl_start_wr),
    .ctrl_stop_wr (ctrl_stop_wr),
    .in_wr_en     (in_wr_en),
    .in_wr_idx    (in_wr_idx),
    .in_wr_data   (in_wr_data),
    .tmo_limit    (tmo_limit),
    .acc_out_valid(acc_out_valid),
    .acc_out_last (acc_out_last),
    .acc_out_data (acc_out_data),
    .out_rd_en    (out_rd_en),
    .acc_start    (acc_start),
    .in_data_reg  (in_data_reg),
    .in_loaded    (in_loaded),
    .out_rd_data  (out_rd_data),
    .out_count    (out_count),
    .busy         (busy),
    .done         (done),
    .err_timeout  (err_timeout),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every acc_start pulse and every effective pop is matched against the queues.
  always @(negedge clk) begin
    int                   e_cyc;
    logic [OUT_WIDTH-1:0] e_dat;
    if (acc_start) begin
      checks++;
      if (exp_start_q.size() == 0) begin
        errors++;
        $display("FAIL acc_start_pulse: got pulse at cycle %0d, required none", cyc);
      end else begin
        e_cyc = exp_start_q.pop_front();
        if (e_cyc != cyc) begin
          errors++;
          $display("FAIL acc_start_cycle: got pulse at cycle %0d, required cycle %0d", cyc, e_cyc);
        end
      end
    end
    if (out_rd_en && out_count != 0) begin
      checks++;
      if (exp_pop_q.size() == 0) begin
        errors++;
        $display("FAIL pop_data: got unexpected pop of %0h, required none", out_rd_data);
      end else begin
        e_dat = exp_pop_q.pop_front();
        if (out_rd_data !== e_dat) begin
          errors++;
          $display("FAIL pop_data: got %0h, required %0h", out_rd_data, e_dat);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int idx, input logic [WORD_WIDTH-1:0] data);
    in_wr_en   = 1'b1;
    in_wr_idx  = IDX_W'(idx);
    in_wr_data = data;
    tick();
    in_wr_en   = 1'b0;
  endtask

  task automatic load_all(input logic [WORD_WIDTH-1:0] base);
    for (int k = 0; k < 32; k++) write_word(k, base + WORD_WIDTH'(k));
  endtask

  task automatic ctrl_write(input logic start, input logic stop, input logic expect_pulse);
    ctrl_wr_en    = 1'b1;
    ctrl_start_wr = start;
    ctrl_stop_wr  = stop;
    tick();
    if (expect_pulse) exp_start_q.push_back(cyc);
    ctrl_wr_en    = 1'b0;
    ctrl_start_wr = 1'b0;
    ctrl_stop_wr  = 1'b0;
  endtask

  task automatic beat(input logic [OUT_WIDTH-1:0] data, input logic last);
    acc_out_valid = 1'b1;
    acc_out_last  = last;
    acc_out_data  = data;
    tick();
    acc_out_valid = 1'b0;
    acc_out_last  = 1'b0;
  endtask

  task automatic pop();
    out_rd_en = 1'b1;
    tick();
    out_rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ctrl_wr_en = 0; ctrl_start_wr = 0; ctrl_stop_wr = 0;
    in_wr_en = 0; in_wr_idx = '0; in_wr_data = '0; tmo_limit = '0;
    acc_out_valid = 0; acc_out_last = 0; acc_out_data = '0; out_rd_en = 0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_acc_start", acc_start, 0);
    check("rst_out_count", out_count, 0);
    check("rst_in_loaded", in_loaded, 0);
    check("rst_in_data_nonzero", |in_data_reg, 0);
    check("rst_out_rd_data", out_rd_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // 31 of 32 words: start must be ignored.
    for (int k = 0; k < 31; k++) write_word(k, WORD_WIDTH'(k));
    check("partial_in_loaded", in_loaded, 0);
    ctrl_write(1'b1, 1'b0, 1'b0);
    tick();
    check("partial_start_busy", busy, 0);
    write_word(31, 32'd31);
    check("full_in_loaded", in_loaded, 1);
    ctrl_write(1'b1, 1'b0, 1'b1);
    check("start_busy", busy, 1);
    check("start_word1", in_data_reg[63:32], 1);
    check("start_word31", in_data_reg[1023:992], 31);
    check("start_in_loaded_cleared", in_loaded, 0);

    // Word writes during RUN are ignored.
    write_word(0, 32'hDEAD);
    check("run_write_ignored", in_data_reg[31:0], 0);

    // Five beats into a depth-4 FIFO, last on the fifth.
    for (int k = 0; k < 5; k++) beat(32'hA0 + 32'(k), k == 4);
    check("ovf_count", out_count, 4);
    check("ovf_err", err_overflow, 1);
    check("ovf_done", done, 1);
    check("ovf_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      exp_pop_q.push_back(32'hA0 + 32'(k));
      pop();
    end
    check("drain_count", out_count, 0);
    pop();
    check("empty_pop_count", out_count, 0);

    // Timeout after 10 RUN cycles with no result beats.
    tmo_limit = 16'd10;
    load_all(32'h0);
    ctrl_write(1'b1, 1'b0, 1'b1);
    check("restart_done_cleared", done, 0);
    check("restart_ovf_cleared", err_overflow, 0);
    tick(9);
    check("tmo_pre_busy", busy, 1);
    check("tmo_pre_err", err_timeout, 0);
    tick();
    check("tmo_busy", busy, 0);
    check("tmo_err", err_timeout, 1);
    check("tmo_done", done, 0);

    // Last beat on the limit cycle resolves as completion.
    load_all(32'h0);
    ctrl_write(1'b1, 1'b0, 1'b1);
    check("restart_tmo_cleared", err_timeout, 0);
    tick(9);
    beat(32'hB0, 1'b1);
    check("lim_done", done, 1);
    check("lim_err_timeout", err_timeout, 0);
    check("lim_busy", busy, 0);
    check("lim_count", out_count, 1);
    exp_pop_q.push_back(32'hB0);
    pop();

    // Full FIFO with simultaneous push and pop, then stop+start mid-RUN.
    tmo_limit = '0;
    load_all(32'h100);
    ctrl_write(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) beat(32'hC0 + 32'(k), 1'b0);
    check("full_count", out_count, 4);
    exp_pop_q.push_back(32'hC0);
    acc_out_valid = 1'b1; acc_out_data = 32'hC4; out_rd_en = 1'b1;
    tick();
    acc_out_valid = 1'b0; out_rd_en = 1'b0;
    check("pushpop_count", out_count, 4);
    check("pushpop_no_ovf", err_overflow, 0);
    ctrl_write(1'b1, 1'b1, 1'b0);
    check("stop_busy", busy, 0);
    check("stop_flush", out_count, 0);
    check("stop_done", done, 0);
    check("stop_data_kept", in_data_reg[63:32], 32'h101);
    check("stop_in_loaded", in_loaded, 0);
    tick(2);
    beat(32'hD0, 1'b1);
    check("idle_beat_ignored", out_count, 0);
    check("idle_beat_done", done, 0);

    // Asynchronous reset in the middle of a job.
    load_all(32'h200);
    ctrl_write(1'b1, 1'b0, 1'b1);
    beat(32'hE0, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_count", out_count, 0);
    check("arst_rd_data", out_rd_data, 0);
    check("arst_in_data_nonzero", |in_data_reg, 0);
    check("arst_acc_start", acc_start, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);

    check("start_queue_drained", exp_start_q.size(), 0);
    check("pop_queue_drained", exp_pop_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_job_ctrl_regs.md
ACC_JOB_CTRL_REGS -- requirements
Module: acc_job_ctrl_regs

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 1024, input-vector width in bits.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, host write-word width; IN_WIDTH is an integer multiple of WORD_WIDTH.
REQ-003 SHALL have parameter OUT_WIDTH, default 32, accelerator result width.
REQ-004 SHALL have parameter OUT_DEPTH, default 4, result FIFO depth (power of two, >=2).
REQ-005 SHALL have parameter TMO_WIDTH, default 16, timeout counter width.
REQ-006 SHALL derive NWORDS = IN_WIDTH/WORD_WIDTH, IDX_W = clog2(NWORDS) (min 1), CNT_W = clog2(OUT_DEPTH)+1.
REQ-007 clk  input  1  sole clock, rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 ctrl_wr_en / ctrl_start_wr / ctrl_stop_wr  input  1 each  control write strobe and start/stop bits.
REQ-010 in_wr_en  input  1  input-word write strobe.
REQ-011 in_wr_idx  input  IDX_W  word index; word k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
REQ-012 in_wr_data  input  WORD_WIDTH  word data.
REQ-013 tmo_limit  input  TMO_WIDTH  RUN-cycle limit; 0 disables timeout.
REQ-014 acc_out_valid / acc_out_last  input  1 each  result beat valid; final beat of job.
REQ-015 acc_out_data  input  OUT_WIDTH  result beat.
REQ-016 out_rd_en  input  1  pop FIFO head.
REQ-017 acc_start  output  1  one-cycle job-start pulse to accelerator.
REQ-018 in_data_reg  output  IN_WIDTH  assembled input vector.
REQ-019 in_loaded  output  1  all NWORDS words written since last job start.
REQ-020 out_rd_data  output  OUT_WIDTH  FIFO head (show-ahead).
REQ-021 out_count  output  CNT_W  FIFO occupancy.
REQ-022 busy / done / err_timeout / err_overflow  output  1 each  status.

Function
REQ-023 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-024 SHALL write in_wr_data into word in_wr_idx and set mask bit in_wr_idx when in_wr_en and state != RUN; writes in RUN ignored; idx >= NWORDS ignored.
REQ-025 in_loaded SHALL equal AND of the NWORDS-bit mask.
REQ-026 Start accepted (ctrl_wr_en & ctrl_start_wr & !ctrl_stop_wr & in_loaded, state IDLE or DONE) in cycle N SHALL give state RUN, busy=1, acc_start=1 in cycle N+1 only, clear mask, done, err_timeout, err_overflow, and timeout counter.
REQ-027 Start with in_loaded=0, or while in RUN, SHALL be ignored with no state change.
REQ-028 ctrl_wr_en & ctrl_stop_wr (any state, priority over start) SHALL go IDLE, clear busy, done, errors, mask, and flush FIFO next cycle; in_data_reg retained.
REQ-029 In RUN, acc_out_valid SHALL push acc_out_data; acc_out_valid outside RUN ignored.
REQ-030 acc_out_valid & acc_out_last in RUN SHALL push the beat and go DONE: busy=0, done=1 next cycle.
REQ-031 Push when full without same-cycle pop SHALL drop the beat and set err_overflow (sticky); full with simultaneous pop SHALL accept both, count unchanged.
REQ-032 Pop when empty SHALL be ignored; out_rd_data undefined-but-stable (holds last array value) when out_count=0.
REQ-033 Timeout counter SHALL increment each RUN cycle, saturating; when tmo_limit!=0 and count reaches tmo_limit with no last beat that cycle, SHALL go IDLE, busy=0, err_timeout=1 (sticky), FIFO retained.
REQ-034 Last beat and timeout in same cycle SHALL resolve as completion (DONE, no error).
REQ-035 FIFO pointers SHALL wrap modulo OUT_DEPTH; out_count range 0..OUT_DEPTH.
REQ-036 Pops SHALL be permitted in every state.

Reset
REQ-037 rst high SHALL immediately force IDLE and zero all outputs, mask, pointers, counters, in_data_reg, FIFO contents; mid-RUN reset aborts the job with no acc_start.

Verification
REQ-038 Load 32 words (word k = k), start -> acc_start one pulse cycle N+1, busy=1, in_data_reg[63:32]=1, in_loaded=0 after start.
REQ-039 Start with 31 words loaded -> no acc_start, state IDLE; write last word, start -> accepted.
REQ-040 RUN, push 5 beats 0xA0..0xA4 (last on 5th), no pops, OUT_DEPTH=4 -> out_count=4, err_overflow=1, done=1, pops return 0xA0..0xA3.
REQ-041 tmo_limit=10, no acc_out_valid -> err_timeout=1 after 10 RUN cycles, busy=0, done=0; last beat at limit cycle -> done=1, err_timeout=0.
REQ-042 Stop and start same write mid-RUN -> IDLE, FIFO empty, no acc_start; rst mid-RUN -> all outputs 0 asynchronously.
